// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide HI/LO unit: op codes, FSM states,
// and the per-op latency helper.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULTU = 3'b000,
    OP_MULT  = 3'b001,
    OP_DIVU  = 3'b010,
    OP_DIV   = 3'b011,
    OP_MADDU = 3'b100,
    OP_MADD  = 3'b101,
    OP_MSUBU = 3'b110,
    OP_MSUB  = 3'b111
  } op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  function automatic int unsigned op_latency(input op_e op,
                                             input int unsigned mul_lat,
                                             input int unsigned div_lat);
    return (op == OP_DIVU || op == OP_DIV) ? div_lat : mul_lat;
  endfunction

  // Odd op codes are the signed variants across every op class.
  function automatic logic op_is_signed(input op_e op);
    return op[0];
  endfunction

endpackage

// File: rtl/muldiv_hilo_unit_if.sv
// Operand/control bundle between the EX stage and the mult/div HI/LO unit.
interface muldiv_hilo_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             flush;
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hilo_we;
  logic             hilo_sel;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output flush, start, op, a, b, hilo_we, hilo_sel, wdata,
    input  busy, hi, lo
  );

  modport slave (
    input  flush, start, op, a, b, hilo_we, hilo_sel, wdata,
    output busy, hi, lo
  );
endinterface

// File: rtl/muldiv_divide.sv
// Combinational signed/unsigned divider with fixed divide-by-zero and
// most-negative / -1 overflow results.
module muldiv_divide
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] uq;
  logic [WIDTH-1:0] ur;

  always_comb begin
    neg_a = is_signed & dividend[WIDTH-1];
    neg_b = is_signed & divisor[WIDTH-1];
    // Two's-complement negation of the most-negative value yields its
    // correct unsigned magnitude, so no extra bit is needed here.
    mag_a = neg_a ? (~dividend + WIDTH'(1)) : dividend;
    mag_b = neg_b ? (~divisor + WIDTH'(1)) : divisor;

    if (mag_b == '0) begin
      uq = '0;
      ur = '0;
    end else begin
      uq = mag_a / mag_b;
      ur = mag_a % mag_b;
    end

    if (divisor == '0) begin
      quotient  = '1;
      remainder = dividend;
    end else if (is_signed && dividend == MOST_NEG && divisor == '1) begin
      quotient  = MOST_NEG;
      remainder = '0;
    end else begin
      quotient  = (neg_a ^ neg_b) ? (~uq + WIDTH'(1)) : uq;
      remainder = neg_a ? (~ur + WIDTH'(1)) : ur;
    end
  end

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Optional MULDIV_MADD_EN enables the maddu/madd/msubu/msub accumulate ops.
module muldiv_hilo_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input logic               clk,
  input logic               reset,
  muldiv_hilo_unit_if.slave bus
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [2*WIDTH-1:0] shadow_q, shadow_d;

  op_e                op_in;
  logic               op_ok;
  logic [2*WIDTH-1:0] prod_u;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] result;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  int unsigned        lat;

  assign op_in = op_e'(bus.op);

  // Low 2*WIDTH bits of the sign-extended product equal the signed product.
  assign prod_u  = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};
  assign prod_s  = {{WIDTH{bus.a[WIDTH-1]}}, bus.a} * {{WIDTH{bus.b[WIDTH-1]}}, bus.b};
  assign product = op_is_signed(op_in) ? prod_s : prod_u;

  muldiv_divide #(
    .WIDTH(WIDTH)
  ) u_divide (
    .is_signed (op_is_signed(op_in)),
    .dividend  (bus.a),
    .divisor   (bus.b),
    .quotient  (quo),
    .remainder (rem)
  );

`ifdef MULDIV_MADD_EN
  assign op_ok = 1'b1;
`else
  assign op_ok = ~bus.op[2];
`endif

  always_comb begin
    case (op_in)
      OP_DIVU, OP_DIV: result = {rem, quo};
`ifdef MULDIV_MADD_EN
      OP_MADDU, OP_MADD: result = {hi_q, lo_q} + product;
      OP_MSUBU, OP_MSUB: result = {hi_q, lo_q} - product;
`endif
      default: result = product;
    endcase
  end

  assign lat = op_latency(op_in, MUL_LAT, DIV_LAT);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    shadow_d = shadow_q;

    case (state_q)
      S_IDLE: begin
        if (!bus.flush) begin
          if (bus.start) begin
            if (op_ok) begin
              shadow_d = result;
              cnt_d    = CNT_W'(lat - 1);
              state_d  = S_RUN;
            end
          end else if (bus.hilo_we) begin
            if (bus.hilo_sel) hi_d = bus.wdata;
            else              lo_d = bus.wdata;
          end
        end
      end
      S_RUN: begin
        if (bus.flush) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          {hi_d, lo_d} = shadow_q;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      shadow_q <= shadow_d;
    end
  end

  assign bus.busy = (state_q == S_RUN);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Scoreboard bench for muldiv_hilo_unit: directed ops push expected HI/LO and
// busy length; a monitor checks on every busy fall and on idle snapshots.
module tb_muldiv_hilo_unit;
  import muldiv_pkg::*;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_hilo_unit_if #(.WIDTH(W)) bus ();

  muldiv_hilo_unit #(
    .WIDTH   (W),
    .MUL_LAT (5),
    .DIV_LAT (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } op_exp_t;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
  } snap_t;

  op_exp_t op_q[$];
  snap_t   snap_q[$];
  int      tests_run    = 0;
  int      tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: busy 1->0 marks an op completing (commit, flush or reset).
  initial begin
    bit      prev_busy = 1'b0;
    int      run_len   = 0;
    op_exp_t e;
    snap_t   s;
    forever begin
      @(negedge clk);
      if (bus.busy === 1'b1) run_len++;
      if (prev_busy && bus.busy !== 1'b1) begin
        if (op_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_op_end: got busy fall expected none");
        end else begin
          e = op_q.pop_front();
          check({e.name, " hi"}, bus.hi, e.hi);
          check({e.name, " lo"}, bus.lo, e.lo);
          check({e.name, " busy_len"}, 32'(run_len), 32'(e.len));
        end
        run_len = 0;
      end
      prev_busy = (bus.busy === 1'b1);
      if (snap_q.size() != 0) begin
        s = snap_q.pop_front();
        check({s.name, " hi"}, bus.hi, s.hi);
        check({s.name, " lo"}, bus.lo, s.lo);
        check({s.name, " busy"}, {31'b0, bus.busy}, {31'b0, s.busy});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic expect_op(input string name, input logic [31:0] hi, input logic [31:0] lo, input int len);
    op_exp_t e;
    e.name = name; e.hi = hi; e.lo = lo; e.len = len;
    op_q.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 40; i++) begin
      if (bus.busy === 1'b0) return;
      tick();
    end
    tests_run++;
    tests_failed++;
    $display("FAIL %s timeout: got busy=1 after 40 cycles expected busy=0", name);
  endtask

  task automatic snap(input string name, input logic [31:0] hi, input logic [31:0] lo, input logic busy);
    snap_t s;
    s.name = name; s.hi = hi; s.lo = lo; s.busy = busy;
    snap_q.push_back(s);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (snap_q.size() == 0) break;
    end
  endtask

  task automatic write_hilo(input logic sel, input logic [31:0] data);
    bus.hilo_we  = 1'b1;
    bus.hilo_sel = sel;
    bus.wdata    = data;
    tick();
    bus.hilo_we  = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                        input int len);
    expect_op(name, hi, lo, len);
    issue(op, a, b);
    wait_idle(name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    bus.flush    = 1'b0;
    bus.start    = 1'b0;
    bus.op       = 3'b000;
    bus.a        = '0;
    bus.b        = '0;
    bus.hilo_we  = 1'b0;
    bus.hilo_sel = 1'b0;
    bus.wdata    = '0;
    tick();
    tick();
    reset = 1'b0;
    snap("reset", 32'h0, 32'h0, 1'b0);

    run_op("mult",       OP_MULT,  32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
    run_op("multu",      OP_MULTU, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, 5);
    run_op("div_neg",    OP_DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    run_op("divu_zero",  OP_DIVU,  32'd7,        32'd0, 32'h00000007, 32'hFFFFFFFF, 10);
    run_op("div_ovf",    OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 10);
    run_op("divu",       OP_DIVU,  32'd100,      32'd7, 32'h2, 32'hE, 10);
    run_op("div_negb",   OP_DIV,   32'd7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 10);
    run_op("div_zero",   OP_DIV,   32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 10);

    write_hilo(1'b1, 32'h11);
    snap("mthi", 32'h11, 32'hFFFFFFFF, 1'b0);
    write_hilo(1'b0, 32'h22);
    snap("mtlo", 32'h11, 32'h22, 1'b0);

    expect_op("flush_c3", 32'h11, 32'h22, 3);
    issue(OP_MULTU, 32'd5, 32'd5);
    tick();
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    wait_idle("flush_c3");
    snap("flush_c3_after", 32'h11, 32'h22, 1'b0);

    expect_op("flush_c5", 32'h11, 32'h22, 5);
    issue(OP_MULTU, 32'd5, 32'd5);
    repeat (4) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    wait_idle("flush_c5");
    snap("flush_c5_after", 32'h11, 32'h22, 1'b0);

    write_hilo(1'b1, 32'hABCD);
    snap("mthi_abcd", 32'hABCD, 32'h22, 1'b0);

    expect_op("we_busy", 32'h0, 32'h19, 5);
    issue(OP_MULTU, 32'd5, 32'd5);
    tick();
    write_hilo(1'b0, 32'h999);
    wait_idle("we_busy");

    expect_op("we_start", 32'h0, 32'hC, 5);
    bus.hilo_we  = 1'b1;
    bus.hilo_sel = 1'b1;
    bus.wdata    = 32'h777;
    issue(OP_MULTU, 32'd3, 32'd4);
    bus.hilo_we  = 1'b0;
    wait_idle("we_start");
    snap("we_start_after", 32'h0, 32'hC, 1'b0);

    bus.flush = 1'b1;
    issue(OP_MULTU, 32'd2, 32'd2);
    bus.flush = 1'b0;
    snap("flush_start_idle", 32'h0, 32'hC, 1'b0);
    bus.flush = 1'b1;
    write_hilo(1'b1, 32'h5555);
    bus.flush = 1'b0;
    snap("flush_we_idle", 32'h0, 32'hC, 1'b0);

    expect_op("b2b", 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
    issue(OP_MULT, 32'hFFFFFFFE, 32'd3);
    tick();
    issue(OP_DIVU, 32'd7, 32'd0);
    wait_idle("b2b");
    snap("b2b_after", 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);

    expect_op("reset_mid", 32'h0, 32'h0, 3);
    issue(OP_DIVU, 32'd100, 32'd7);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    snap("reset_mid_after", 32'h0, 32'h0, 1'b0);

    write_hilo(1'b0, 32'hFFFFFFFF);
    snap("pre_madd", 32'h0, 32'hFFFFFFFF, 1'b0);
`ifdef MULDIV_MADD_EN
    run_op("maddu", OP_MADDU, 32'd1, 32'd1, 32'h1, 32'h0, 5);
    run_op("msub",  OP_MSUB,  32'd1, 32'd1, 32'h0, 32'hFFFFFFFF, 5);
    run_op("madd",  OP_MADD,  32'hFFFFFFFF, 32'd1, 32'h0, 32'hFFFFFFFE, 5);
`else
    issue(OP_MADDU, 32'd1, 32'd1);
    snap("noop_100", 32'h0, 32'hFFFFFFFF, 1'b0);
    issue(OP_MSUB, 32'd1, 32'd1);
    snap("noop_111", 32'h0, 32'hFFFFFFFF, 1'b0);
`endif

    repeat (3) tick();
    tests_run++;
    if (op_q.size() != 0) begin
      tests_failed++;
      $display("FAIL pending_ops: got %0d outstanding expected 0", op_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
